// File: rtl/gba_lcd_pkg.sv
// Shared state encoding and default geometry for the GBA LCD timing generator.
package gba_lcd_pkg;

  typedef enum logic [1:0] {
    VISIBLE      = 2'd0,
    HBLANK       = 2'd1,
    VBLANK       = 2'd2,
    VBLANKHBLANK = 2'd3
  } lcd_state_e;

  localparam int unsigned DEF_CYC_W     = 12;
  localparam int unsigned DEF_LINE_W    = 8;
  localparam int unsigned DEF_H_VIS     = 1008;
  localparam int unsigned DEF_H_BLK     = 224;
  localparam int unsigned DEF_V_VIS     = 160;
  localparam int unsigned DEF_V_TOT     = 228;
  localparam int unsigned DEF_PIX_START = 160;
  localparam int unsigned DEF_VRAM_END  = 980;
  localparam int unsigned DEF_DMA_FIRST = 2;
  localparam int unsigned DEF_DMA_LAST  = 162;
  localparam int unsigned DEF_NCMP      = 2;

endpackage

// File: rtl/gba_vcmp_chan.sv
// One V-counter compare channel.
// Ports: fclk/reset_n clock and async reset; clr synchronous clear (frame resync);
//        strobe marks a line change; next_line is line+1 without wrap; wrap marks
//        the wrap to line 0; setting is the compare line; en gates the IRQ pulse.
//        flag is the held match level, irq a one-cycle pulse.
module gba_vcmp_chan
  import gba_lcd_pkg::*;
#(
  parameter int unsigned LINE_W = DEF_LINE_W,
  parameter int unsigned V_TOT  = DEF_V_TOT
) (
  input  logic              fclk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              strobe,
  input  logic [LINE_W:0]   next_line,
  input  logic              wrap,
  input  logic [LINE_W-1:0] setting,
  input  logic              en,
  output logic              flag,
  output logic              irq
);

  logic match_c;

  // Settings beyond the last line can never match; the wrap enters line 0.
  assign match_c = ({1'b0, setting} < (LINE_W+1)'(V_TOT)) &&
                   (wrap ? (setting == '0) : (next_line == {1'b0, setting}));

  always_ff @(posedge fclk or negedge reset_n) begin
    if (!reset_n) begin
      flag <= 1'b0;
      irq  <= 1'b0;
    end else if (clr) begin
      flag <= 1'b0;
      irq  <= 1'b0;
    end else begin
      irq <= strobe & match_c & en;
      if (strobe) flag <= match_c;
    end
  end

endmodule

// File: rtl/gba_lcd_timing_gen.sv
// Cycle-counted LCD timing generator.
// Ports: fclk/reset_n clock and async active-low reset; enable freezes everything;
//        resync restarts the frame; lockspeed gates drawing on cycle position;
//        new_cycles/new_cycles_valid is the CPU cycle budget; *_irq_en and
//        vcmp_setting configure interrupts and compare lines.  Outputs are the
//        DISPSTAT flags, vcount, pixelpos, single-cycle strobes for the drawer,
//        DMA and IRQ units, and the registered vram_blocked level.
module gba_lcd_timing_gen
  import gba_lcd_pkg::*;
#(
  parameter int unsigned CYC_W     = DEF_CYC_W,
  parameter int unsigned LINE_W    = DEF_LINE_W,
  parameter int unsigned H_VIS     = DEF_H_VIS,
  parameter int unsigned H_BLK     = DEF_H_BLK,
  parameter int unsigned V_VIS     = DEF_V_VIS,
  parameter int unsigned V_TOT     = DEF_V_TOT,
  parameter int unsigned PIX_START = DEF_PIX_START,
  parameter int unsigned VRAM_END  = DEF_VRAM_END,
  parameter int unsigned DMA_FIRST = DEF_DMA_FIRST,
  parameter int unsigned DMA_LAST  = DEF_DMA_LAST,
  parameter int unsigned NCMP      = DEF_NCMP
) (
  input  logic                   fclk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   resync,
  input  logic                   lockspeed,
  input  logic                   vram_block_mode,
  input  logic [7:0]             new_cycles,
  input  logic                   new_cycles_valid,
  input  logic                   hblank_irq_en,
  input  logic                   vblank_irq_en,
  input  logic [NCMP-1:0]        vcmp_irq_en,
  input  logic [NCMP*LINE_W-1:0] vcmp_setting,
  output logic                   hblank_flag,
  output logic                   vblank_flag,
  output logic [NCMP-1:0]        vcmp_flag,
  output logic [LINE_W-1:0]      vcount,
  output logic [8:0]             pixelpos,
  output logic                   irq_hblank,
  output logic                   irq_vblank,
  output logic [NCMP-1:0]        irq_vcmp,
  output logic                   line_trigger,
  output logic                   hblank_trigger,
  output logic                   vblank_trigger,
  output logic                   drawline,
  output logic                   refpoint_update,
  output logic                   newline_invsync,
  output logic                   videodma_start,
  output logic                   videodma_stop,
  output logic                   vram_blocked
);

  lcd_state_e        state;
  logic [CYC_W-1:0]  acc;
  logic [LINE_W-1:0] line;
  logic              drawsoon;

  logic [CYC_W-1:0]  budget_c;
  logic [CYC_W-1:0]  cyc_c;
  logic [LINE_W:0]   line_inc_c;
  logic              hb_done_c;
  logic              cmp_strobe_c;
  logic              cmp_wrap_c;
  logic              draw_gate_c;

  // Budget for this clock is folded in before any phase compare.
  assign budget_c    = (new_cycles_valid && enable) ? CYC_W'(new_cycles) : '0;
  assign cyc_c       = acc + budget_c;
  assign line_inc_c  = {1'b0, line} + (LINE_W+1)'(1);
  assign hb_done_c   = (cyc_c >= CYC_W'(H_BLK));
  assign draw_gate_c = !lockspeed || (cyc_c >= CYC_W'(PIX_START));

  // Every hblank end is a line change and updates the compare channels.
  assign cmp_strobe_c = enable && !resync && hb_done_c &&
                        ((state == HBLANK) || (state == VBLANKHBLANK));
  assign cmp_wrap_c   = (state == VBLANKHBLANK) && (line_inc_c == (LINE_W+1)'(V_TOT));

  assign vcount = line;

  // Phase walker: at most one transition per clock, remainder carried in acc.
  always_ff @(posedge fclk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= VISIBLE;
      acc             <= '0;
      line            <= '0;
      drawsoon        <= 1'b1;
      hblank_flag     <= 1'b0;
      vblank_flag     <= 1'b0;
      pixelpos        <= '0;
      irq_hblank      <= 1'b0;
      irq_vblank      <= 1'b0;
      line_trigger    <= 1'b0;
      hblank_trigger  <= 1'b0;
      vblank_trigger  <= 1'b0;
      drawline        <= 1'b0;
      refpoint_update <= 1'b0;
      newline_invsync <= 1'b0;
      videodma_start  <= 1'b0;
      videodma_stop   <= 1'b0;
      vram_blocked    <= 1'b0;
    end else if (resync) begin
      state           <= VISIBLE;
      acc             <= '0;
      line            <= '0;
      drawsoon        <= 1'b1;
      hblank_flag     <= 1'b0;
      vblank_flag     <= 1'b0;
      pixelpos        <= '0;
      irq_hblank      <= 1'b0;
      irq_vblank      <= 1'b0;
      line_trigger    <= 1'b1;
      hblank_trigger  <= 1'b0;
      vblank_trigger  <= 1'b0;
      drawline        <= 1'b0;
      refpoint_update <= 1'b0;
      newline_invsync <= 1'b0;
      videodma_start  <= 1'b0;
      videodma_stop   <= 1'b0;
      vram_blocked    <= 1'b0;
    end else begin
      irq_hblank      <= 1'b0;
      irq_vblank      <= 1'b0;
      line_trigger    <= 1'b0;
      hblank_trigger  <= 1'b0;
      vblank_trigger  <= 1'b0;
      drawline        <= 1'b0;
      refpoint_update <= 1'b0;
      newline_invsync <= 1'b0;
      videodma_start  <= 1'b0;
      videodma_stop   <= 1'b0;
      if (enable) begin
        acc          <= cyc_c;
        vram_blocked <= (state == VISIBLE) && vram_block_mode && (cyc_c < CYC_W'(VRAM_END));
        unique case (state)
          VISIBLE: begin
            if (draw_gate_c && drawsoon) begin
              drawline <= 1'b1;
              drawsoon <= 1'b0;
            end
            if (lockspeed && (cyc_c >= CYC_W'(PIX_START)))
              pixelpos <= 9'((cyc_c >> 1) - CYC_W'(PIX_START / 2));
            if (cyc_c >= CYC_W'(H_VIS)) begin
              state          <= HBLANK;
              acc            <= cyc_c - CYC_W'(H_VIS);
              hblank_flag    <= 1'b1;
              hblank_trigger <= 1'b1;
              pixelpos       <= 9'd240;
              irq_hblank     <= hblank_irq_en;
              videodma_start <= (line >= LINE_W'(DMA_FIRST));
            end
          end
          HBLANK: begin
            if (hb_done_c) begin
              acc         <= cyc_c - CYC_W'(H_BLK);
              hblank_flag <= 1'b0;
              line        <= line_inc_c[LINE_W-1:0];
              if (line_inc_c < (LINE_W+1)'(V_VIS)) begin
                state        <= VISIBLE;
                line_trigger <= 1'b1;
                drawsoon     <= 1'b1;
                pixelpos     <= '0;
              end else begin
                state           <= VBLANK;
                vblank_flag     <= 1'b1;
                vblank_trigger  <= 1'b1;
                refpoint_update <= 1'b1;
                irq_vblank      <= vblank_irq_en;
              end
            end
          end
          VBLANK: begin
            if (cyc_c >= CYC_W'(H_VIS)) begin
              state           <= VBLANKHBLANK;
              acc             <= cyc_c - CYC_W'(H_VIS);
              hblank_flag     <= 1'b1;
              newline_invsync <= 1'b1;
              irq_hblank      <= hblank_irq_en;
              videodma_start  <= (line < LINE_W'(DMA_LAST));
              videodma_stop   <= (line == LINE_W'(DMA_LAST));
            end
          end
          VBLANKHBLANK: begin
            if (hb_done_c) begin
              acc          <= cyc_c - CYC_W'(H_BLK);
              hblank_flag  <= 1'b0;
              line_trigger <= 1'b1;
              if (cmp_wrap_c) begin
                line     <= '0;
                state    <= VISIBLE;
                drawsoon <= 1'b1;
                pixelpos <= '0;
              end else begin
                line  <= line_inc_c[LINE_W-1:0];
                state <= VBLANK;
                if (line_inc_c == (LINE_W+1)'(V_TOT - 1)) vblank_flag <= 1'b0;
              end
            end
          end
          default: state <= VISIBLE;
        endcase
      end
    end
  end

  // Independent compare channels.
  for (genvar i = 0; i < NCMP; i++) begin : g_vcmp
    gba_vcmp_chan #(
      .LINE_W (LINE_W),
      .V_TOT  (V_TOT)
    ) u_chan (
      .fclk      (fclk),
      .reset_n   (reset_n),
      .clr       (resync),
      .strobe    (cmp_strobe_c),
      .next_line (line_inc_c),
      .wrap      (cmp_wrap_c),
      .setting   (vcmp_setting[i*LINE_W +: LINE_W]),
      .en        (vcmp_irq_en[i]),
      .flag      (vcmp_flag[i]),
      .irq       (irq_vcmp[i])
    );
  end

endmodule

// File: tb/tb_gba_lcd_timing_gen.sv
// Self-checking bench for gba_lcd_timing_gen with a line/phase reference model.
module tb_gba_lcd_timing_gen;

  localparam int H_VIS = 1008, H_BLK = 224, V_VIS = 160, V_TOT = 228;
  localparam int PIX_START = 160, VRAM_END = 980, DMA_FIRST = 2, DMA_LAST = 162;

  logic        fclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0, resync = 1'b0, lockspeed = 1'b0, vram_block_mode = 1'b0;
  logic [7:0]  new_cycles = 8'd0;
  logic        new_cycles_valid = 1'b0;
  logic        hblank_irq_en = 1'b0, vblank_irq_en = 1'b0;
  logic [1:0]  vcmp_irq_en = 2'b00;
  logic [15:0] vcmp_setting = 16'd0;

  logic        hblank_flag, vblank_flag, irq_hblank, irq_vblank;
  logic [1:0]  vcmp_flag, irq_vcmp;
  logic [7:0]  vcount;
  logic [8:0]  pixelpos;
  logic        line_trigger, hblank_trigger, vblank_trigger, drawline, refpoint_update;
  logic        newline_invsync, videodma_start, videodma_stop, vram_blocked;

  always #5 fclk = ~fclk;

  gba_lcd_timing_gen dut (
    .fclk(fclk), .reset_n(reset_n), .enable(enable), .resync(resync),
    .lockspeed(lockspeed), .vram_block_mode(vram_block_mode),
    .new_cycles(new_cycles), .new_cycles_valid(new_cycles_valid),
    .hblank_irq_en(hblank_irq_en), .vblank_irq_en(vblank_irq_en),
    .vcmp_irq_en(vcmp_irq_en), .vcmp_setting(vcmp_setting),
    .hblank_flag(hblank_flag), .vblank_flag(vblank_flag), .vcmp_flag(vcmp_flag),
    .vcount(vcount), .pixelpos(pixelpos), .irq_hblank(irq_hblank),
    .irq_vblank(irq_vblank), .irq_vcmp(irq_vcmp), .line_trigger(line_trigger),
    .hblank_trigger(hblank_trigger), .vblank_trigger(vblank_trigger),
    .drawline(drawline), .refpoint_update(refpoint_update),
    .newline_invsync(newline_invsync), .videodma_start(videodma_start),
    .videodma_stop(videodma_stop), .vram_blocked(vram_blocked)
  );

  // Pulse vector bit positions.
  localparam int P_IRQH = 11, P_IRQV = 10, P_IRQC = 8, P_LINE = 7, P_HTRIG = 6;
  localparam int P_VTRIG = 5, P_DRAW = 4, P_REF = 3, P_INV = 2, P_DMAS = 1, P_DMAE = 0;

  logic [11:0] dut_pulse;
  assign dut_pulse = {irq_hblank, irq_vblank, irq_vcmp, line_trigger, hblank_trigger,
                      vblank_trigger, drawline, refpoint_update, newline_invsync,
                      videodma_start, videodma_stop};

  int n_pass = 0, n_total = 0;

  // Model: current line, whether we are in the hblank part of it, cycle remainder.
  int       m_line, m_acc;
  bit       m_hb, m_ds;
  bit       e_hflag, e_vflag, e_vram;
  bit [1:0] e_vcf;
  int       e_pix;
  bit [11:0] e_pulse;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_line = 0; m_acc = 0; m_hb = 0; m_ds = 1;
    e_hflag = 0; e_vflag = 0; e_vram = 0; e_vcf = 0; e_pix = 0; e_pulse = 0;
  endtask

  task automatic model_step();
    int cyc, lim, nl, s;
    bit vis;
    e_pulse = 0;
    if (resync) begin
      model_reset();
      e_pulse[P_LINE] = 1;
      return;
    end
    if (!enable) return;
    cyc = m_acc + (new_cycles_valid ? int'(new_cycles) : 0);
    vis = !m_hb && (m_line < V_VIS);
    e_vram = vis && vram_block_mode && (cyc < VRAM_END);
    if (vis) begin
      if ((!lockspeed || cyc >= PIX_START) && m_ds) begin e_pulse[P_DRAW] = 1; m_ds = 0; end
      if (lockspeed && cyc >= PIX_START) e_pix = (cyc / 2 - PIX_START / 2) % 512;
    end
    lim = m_hb ? H_BLK : H_VIS;
    m_acc = cyc;
    if (cyc >= lim) begin
      m_acc = cyc - lim;
      if (!m_hb) begin
        m_hb = 1; e_hflag = 1; e_pulse[P_IRQH] = hblank_irq_en;
        if (m_line < V_VIS) begin
          e_pulse[P_HTRIG] = 1; e_pix = 240; e_pulse[P_DMAS] = (m_line >= DMA_FIRST);
        end else begin
          e_pulse[P_INV] = 1;
          e_pulse[P_DMAS] = (m_line < DMA_LAST);
          e_pulse[P_DMAE] = (m_line == DMA_LAST);
        end
      end else begin
        m_hb = 0; e_hflag = 0;
        nl = (m_line + 1) % V_TOT;
        if (nl == V_VIS) begin
          e_pulse[P_VTRIG] = 1; e_pulse[P_REF] = 1; e_pulse[P_IRQV] = vblank_irq_en;
        end else begin
          e_pulse[P_LINE] = 1;
          if (nl < V_VIS) begin m_ds = 1; e_pix = 0; end
        end
        e_vflag = (nl >= V_VIS) && (nl < V_TOT - 1);
        for (int i = 0; i < 2; i++) begin
          s = int'(vcmp_setting[i*8 +: 8]);
          e_vcf[i] = (s < V_TOT) && (s == nl);
          e_pulse[P_IRQC + i] = e_vcf[i] && vcmp_irq_en[i];
        end
        m_line = nl;
      end
    end
  endtask

  task automatic compare_all();
    chk("vcount", 32'(vcount), 32'(m_line));
    chk("pixelpos", 32'(pixelpos), 32'(e_pix));
    chk("flags", 32'({hblank_flag, vblank_flag, vcmp_flag}), 32'({e_hflag, e_vflag, e_vcf}));
    chk("pulses", 32'(dut_pulse), 32'(e_pulse));
    chk("vram_blocked", 32'(vram_blocked), 32'(e_vram));
  endtask

  task automatic cycle();
    model_step();
    @(posedge fclk);
    @(negedge fclk);
    compare_all();
  endtask

  task automatic randomize_inputs(input int resync_odds);
    enable           = ($urandom_range(0, 9) != 0);
    resync           = ($urandom_range(0, resync_odds - 1) == 0);
    new_cycles_valid = ($urandom_range(0, 3) != 0);
    new_cycles       = 8'($urandom_range(0, 255));
  endtask

  function automatic logic [7:0] pick_setting();
    logic [7:0] tbl [8];
    tbl = '{8'd0, 8'd5, 8'd159, 8'd160, 8'd161, 8'd227, 8'd228, 8'd255};
    return tbl[$urandom_range(0, 7)];
  endfunction

  initial begin
    int first_h, first_l, vcnt_l, vtrig_at, vfall_at, wrap_at, n_dmas, n_dmae, n_c0, n_c1, n_both;
    int acc0, fed, used, guard;
    logic [7:0] fr_vc;
    logic [8:0] fr_pp;
    logic [3:0] fr_fl;
    bit         any_pulse;

    model_reset();
    repeat (3) @(negedge fclk);
    compare_all();
    reset_n = 1'b1;

    // Fixed 16-cycle budget from reset through one complete frame.
    enable = 1; new_cycles_valid = 1; new_cycles = 8'd16;
    hblank_irq_en = 1; vblank_irq_en = 1; vcmp_irq_en = 2'b11; vcmp_setting = {8'd0, 8'd5};
    first_h = 0; first_l = 0; vcnt_l = -1; vtrig_at = 0; vfall_at = 0; wrap_at = 0;
    n_dmas = 0; n_dmae = 0; n_c0 = 0; n_c1 = 0; n_both = 0;
    for (int n = 1; n <= 17556; n++) begin
      bit pv;
      pv = vblank_flag;
      cycle();
      if (hblank_trigger && first_h == 0) first_h = n;
      if (line_trigger && first_l == 0) begin first_l = n; vcnt_l = int'(vcount); end
      if (vblank_trigger && vtrig_at == 0 && irq_vblank && vcount == 8'd160) vtrig_at = n;
      if (pv && !vblank_flag && vcount == 8'd227) vfall_at = n;
      if (line_trigger && vcount == 8'd0) wrap_at = n;
      n_dmas += int'(videodma_start);
      n_dmae += int'(videodma_stop);
      if (irq_vcmp[0] && vcount == 8'd5) n_c0++;
      if (irq_vcmp[1] && vcount == 8'd0) n_c1++;
      if (irq_vcmp == 2'b11) n_both++;
    end
    chk("first_hblank_clk", 32'(first_h), 32'd63);
    chk("first_line_clk", 32'(first_l), 32'd77);
    chk("vcount_at_line1", 32'(vcnt_l), 32'd1);
    chk("vblank_trig_clk", 32'(vtrig_at), 32'd12320);
    chk("vblank_fall_clk", 32'(vfall_at), 32'd17479);
    chk("frame_wrap_clk", 32'(wrap_at), 32'd17556);
    chk("dma_start_count", 32'(n_dmas), 32'd160);
    chk("dma_stop_count", 32'(n_dmae), 32'd1);
    chk("vcmp0_irq_count", 32'(n_c0), 32'd1);
    chk("vcmp1_irq_count", 32'(n_c1), 32'd1);
    chk("vcmp_both_count", 32'(n_both), 32'd0);

    // Maximum budget every clock: cycle conservation.
    new_cycles = 8'd255; new_cycles_valid = 1; enable = 1; resync = 0;
    acc0 = m_acc; fed = 0; used = 0;
    for (int n = 0; n < 3000; n++) begin
      cycle();
      fed += 255;
      if (hblank_trigger || newline_invsync) used += H_VIS;
      if (line_trigger || vblank_trigger) used += H_BLK;
    end
    chk("cycles_conserved", 32'(acc0 + fed - used), 32'(m_acc));

    // Randomized traffic.
    for (int seg = 0; seg < 12; seg++) begin
      lockspeed = 1'($urandom_range(0, 1));
      vram_block_mode = 1'($urandom_range(0, 1));
      hblank_irq_en = 1'($urandom_range(0, 1));
      vblank_irq_en = 1'($urandom_range(0, 1));
      vcmp_irq_en = 2'($urandom_range(0, 3));
      vcmp_setting = {pick_setting(), pick_setting()};
      for (int n = 0; n < 700; n++) begin
        randomize_inputs(1500);
        cycle();
      end
    end
    resync = 0; enable = 1; new_cycles_valid = 1; new_cycles = 8'd16; lockspeed = 0;

    // Freeze mid-HBLANK.
    guard = 0;
    while (!(hblank_flag && !vblank_flag) && guard < 3000) begin cycle(); guard++; end
    chk("reach_hblank", 32'(guard < 3000), 32'd1);
    fr_vc = vcount; fr_pp = pixelpos; fr_fl = {hblank_flag, vblank_flag, vcmp_flag};
    any_pulse = 0;
    enable = 0;
    for (int n = 0; n < 50; n++) begin
      new_cycles = 8'($urandom_range(0, 255));
      cycle();
      any_pulse |= (dut_pulse != 0);
    end
    chk("freeze_vcount", 32'(vcount), 32'(fr_vc));
    chk("freeze_pixelpos", 32'(pixelpos), 32'(fr_pp));
    chk("freeze_flags", 32'({hblank_flag, vblank_flag, vcmp_flag}), 32'(fr_fl));
    chk("freeze_no_pulse", 32'(any_pulse), 32'd0);

    // Resync at line 100.
    enable = 1; new_cycles = 8'd255;
    guard = 0;
    while (vcount != 8'd100 && guard < 20000) begin cycle(); guard++; end
    chk("reach_line100", 32'(guard < 20000), 32'd1);
    resync = 1;
    cycle();
    resync = 0;
    chk("resync_vcount", 32'(vcount), 32'd0);
    chk("resync_line_trig", 32'(line_trigger), 32'd1);

    // Asynchronous reset mid-VBLANK.
    guard = 0;
    while (!vblank_flag && guard < 20000) begin cycle(); guard++; end
    chk("reach_vblank", 32'(guard < 20000), 32'd1);
    new_cycles_valid = 0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_reset_outs", 32'({dut_pulse, hblank_flag, vblank_flag, vcmp_flag, vram_blocked}), 32'd0);
    chk("async_reset_pos", 32'({vcount, pixelpos}), 32'd0);
    @(negedge fclk);
    @(negedge fclk);
    reset_n = 1'b1;
    new_cycles_valid = 1; new_cycles = 8'd16;
    cycle();
    chk("first_draw_after_reset", 32'(drawline), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
